mult_div_unit: RTL and testbench



---
 rtl/mips_pkg.sv | 22 ++
 rtl/mult_div_unit_if.sv | 21 ++
 rtl/mult_div_unit.sv | 137 +++++++++++++
 tb/tb_mult_div_unit.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath types: multiply/divide opcodes, unit states and iteration count.
package mips_pkg;

  localparam int WIDTH   = 32;
  localparam int MD_ITER = WIDTH;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    FIN  = 3'd4
  } md_state_t;

endpackage

// File: rtl/mult_div_unit_if.sv
// Control-unit <-> multiply/divide unit handshake plus continuously visible Hi/Lo.
interface mult_div_if
  import mips_pkg::*;
#(
  parameter int WIDTH = MD_ITER
);
  logic             Start;
  logic [1:0]       MDOp;
  logic [WIDTH-1:0] OpA;
  logic [WIDTH-1:0] OpB;
  logic             Busy;
  logic             Done;
  logic             DivZero;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  modport master (output Start, MDOp, OpA, OpB,
                  input  Busy, Done, DivZero, Hi, Lo);
  modport slave  (input  Start, MDOp, OpA, OpB,
                  output Busy, Done, DivZero, Hi, Lo);
endinterface

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier and restoring divider sharing one 2*WIDTH working register.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = MD_ITER
) (
  input  logic       Clk,
  input  logic       Reset,
  mult_div_if.slave  md
);

  localparam int CW = $clog2(WIDTH);

  md_state_t          state_q, state_d;
  md_op_t             op_q, op_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               divz_q, divz_d;

  logic               signed_op;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] prod;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
  endfunction

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      op_q      <= MD_MULT;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      divz_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      divz_q    <= divz_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    divz_d    = divz_q;

    signed_op = (md.MDOp == MD_MULT) || (md.MDOp == MD_DIV);
    a_mag     = mag(md.OpA, signed_op);
    b_mag     = mag(md.OpB, signed_op);
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
    // Remainder is shifted into WIDTH+1 bits so a divisor with its MSB set still compares correctly
    div_ge    = acc_q[2*WIDTH-1:WIDTH-1] >= {1'b0, opb_q};
    div_rem   = WIDTH'(acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opb_q});
    prod      = neg_res_q ? -acc_q : acc_q;

    case (state_q)
      IDLE, FIN: begin
        divz_d  = 1'b0;
        state_d = IDLE;
        if (md.Start) begin
          op_d      = md_op_t'(md.MDOp);
          neg_res_d = signed_op && (md.OpA[WIDTH-1] ^ md.OpB[WIDTH-1]);
          neg_rem_d = signed_op && md.OpA[WIDTH-1];
          cnt_d     = CW'(WIDTH-1);
          if (md.MDOp[1]) begin
            if (md.OpB == '0) begin
              state_d = FIN;
              divz_d  = 1'b1;
            end else begin
              state_d = DIV;
              acc_d   = {{WIDTH{1'b0}}, a_mag};
              opb_d   = b_mag;
            end
          end else begin
            state_d = MUL;
            acc_d   = {{WIDTH{1'b0}}, b_mag};
            opb_d   = a_mag;
          end
        end
      end
      MUL, DIV: begin
        if (state_q == MUL) begin
          acc_d = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
        end else begin
          acc_d = div_ge ? {div_rem, acc_q[WIDTH-2:0], 1'b1} : {acc_q[2*WIDTH-2:0], 1'b0};
        end
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - CW'(1);
      end
      FIX: begin
        state_d = FIN;
        if (!op_q[1]) begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else begin
          lo_d = neg_res_q ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
          hi_d = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign md.Busy    = (state_q == MUL) || (state_q == DIV) || (state_q == FIX);
  assign md.Done    = (state_q == FIN);
  assign md.DivZero = divz_q;
  assign md.Hi      = hi_q;
  assign md.Lo      = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed ops push expected Hi/Lo/DivZero, a monitor checks on Done.
module tb_mult_div_unit;
  import mips_pkg::*;

  logic Clk;
  logic Reset;

  mult_div_if #(.WIDTH(32)) md ();

  mult_div_unit #(.WIDTH(32)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .md    (md)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every Done must match the oldest outstanding expectation
  always @(negedge Clk) begin
    if (md.Done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(md.Done), 64'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_hi"},      64'(md.Hi),      64'(e.hi));
        check({e.name, "_lo"},      64'(md.Lo),      64'(e.lo));
        check({e.name, "_divzero"}, 64'(md.DivZero), 64'(e.dz));
        check({e.name, "_busy_at_done"}, 64'(md.Busy), 64'(0));
      end
    end
  end

  // Called at a negedge; returns at the negedge where Done is seen
  task automatic run_op(input string name, input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                        input int exp_done, input int exp_busy, input int extra_at);
    exp_t e;
    int   done_n;
    int   busy_n;
    e.hi = ehi; e.lo = elo; e.dz = edz; e.name = name;
    sb.push_back(e);
    md.Start = 1'b1;
    md.MDOp  = op;
    md.OpA   = a;
    md.OpB   = b;
    done_n = 0;
    busy_n = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge Clk);
      if (n == 1) begin
        md.Start = 1'b0;
        md.MDOp  = 2'($urandom);
        md.OpA   = $urandom;
        md.OpB   = $urandom;
      end
      if (extra_at > 0 && n == extra_at) begin
        md.Start = 1'b1;
        md.MDOp  = MD_MULTU;
        md.OpA   = 32'd3;
        md.OpB   = 32'd4;
      end
      if (extra_at > 0 && n == extra_at + 1) md.Start = 1'b0;
      if (md.Busy) busy_n++;
      if (md.Done) begin
        done_n = n;
        break;
      end
    end
    if (done_n == 0) $display("FAIL %s_timeout: no Done within 60 cycles", name);
    check({name, "_done_cycle"}, 64'(done_n), 64'(exp_done));
    check({name, "_busy_cycles"}, 64'(busy_n), 64'(exp_busy));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    Reset    = 1'b1;
    md.Start = 1'b0;
    md.MDOp  = 2'b00;
    md.OpA   = '0;
    md.OpB   = '0;
    repeat (2) @(negedge Clk);
    check("reset_busy",    64'(md.Busy),    64'(0));
    check("reset_done",    64'(md.Done),    64'(0));
    check("reset_divzero", 64'(md.DivZero), 64'(0));
    check("reset_hi",      64'(md.Hi),      64'(0));
    check("reset_lo",      64'(md.Lo),      64'(0));
    Reset = 1'b0;
    @(negedge Clk);

    run_op("mult_7_m3",     MD_MULT,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34, 33, 0);
    run_op("multu_max",     MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34, 33, 0);
    run_op("div_m7_2",      MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34, 33, 0);
    run_op("div_min_m1",    MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34, 33, 0);
    run_op("div_7_m2",      MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34, 33, 0);
    run_op("mult_min_min",  MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34, 33, 0);
    run_op("divu_100_7",    MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 34, 33, 0);
    run_op("divu_prior",    MD_DIVU,  32'h00000451, 32'h00000020, 32'h00000011, 32'h00000022, 1'b0, 34, 33, 0);
    run_op("divu_5_0",      MD_DIVU,  32'd5,        32'd0,        32'h00000011, 32'h00000022, 1'b1, 1,  0,  0);
    run_op("div_min_0",     MD_DIV,   32'h80000000, 32'd0,        32'h00000011, 32'h00000022, 1'b1, 1,  0,  0);
    run_op("mult_ignore",   MD_MULT,  32'hFFFFFFF6, 32'd100,      32'hFFFFFFFF, 32'hFFFFFC18, 1'b0, 34, 33, 5);

    // Abort a multiply mid-flight: everything clears, no Done may follow
    md.Start = 1'b1;
    md.MDOp  = MD_MULT;
    md.OpA   = 32'd5;
    md.OpB   = 32'd6;
    @(negedge Clk);
    md.Start = 1'b0;
    repeat (9) @(negedge Clk);
    Reset = 1'b1;
    #1;
    check("abort_busy", 64'(md.Busy), 64'(0));
    check("abort_done", 64'(md.Done), 64'(0));
    check("abort_hi",   64'(md.Hi),   64'(0));
    check("abort_lo",   64'(md.Lo),   64'(0));
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    repeat (40) @(negedge Clk);

    run_op("multu_3_4",     MD_MULTU, 32'd3,        32'd4,        32'd0,        32'd12,       1'b0, 34, 33, 0);

    repeat (3) @(negedge Clk);
    check("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
